// File: rtl/axis_frame_tx_pkg.sv
// Shared definitions for the AXI-Stream frame transmitter.
//   state_e    : transmitter FSM encoding (IDLE=0, SEND=1)
//   keep_mask  : byte-enable mask for a beat given the bytes still to send
package axis_frame_tx_pkg;

    // Upper bound on byte lanes; the beat generator truncates to its own width.
    localparam int unsigned MAX_KEEP_WIDTH = 128;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // Bit i is set iff lane i still carries a frame byte (i < remaining).
    function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(input logic [31:0] remaining);
        logic [MAX_KEEP_WIDTH-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
            mask[i] = (i < remaining);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_tx_beat_gen.sv
// Combinational beat builder for axis_frame_tx.
// Inputs : pattern   - byte value carried by lane 0 of this beat
//          remaining - bytes of the frame not yet sent, including this beat
// Outputs: tdata     - incrementing byte pattern, unused lanes zeroed
//          tkeep     - byte enables (all ones when KEEP_ENABLE is 0)
//          tlast     - this beat finishes the frame
module axis_tx_beat_gen
    import axis_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic [7:0]            pattern,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [KEEP_WIDTH-1:0] tkeep,
    output logic                  tlast
);

    logic [KEEP_WIDTH-1:0] lane_mask;

    assign lane_mask = KEEP_WIDTH'(keep_mask(32'(remaining)));
    assign tkeep     = KEEP_ENABLE ? lane_mask : {KEEP_WIDTH{1'b1}};
    assign tlast     = (remaining <= LEN_WIDTH'(KEEP_WIDTH));

    always_comb begin
        tdata = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            // Lanes past the end of the frame carry zero.
            tdata[8*i +: 8] = lane_mask[i] ? (pattern + 8'(i)) : 8'h00;
        end
    end

endmodule

// File: rtl/axis_frame_tx.sv
// Descriptor-driven AXI-Stream frame source.
// Descriptor in : s_desc_len/id/dest/user/seed with s_desc_valid/s_desc_ready.
// Stream out    : m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser, m_axis_tready.
// Status        : status_busy (in SEND), status_frame_done and status_bad_desc
//                 single-cycle pulses.
// Each non-zero-length descriptor produces one frame whose byte k is seed+k (mod 256).
// All m_axis_* outputs come straight from registers.
module axis_frame_tx
    import axis_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned DEST_WIDTH  = 8,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  s_desc_len,
    input  logic [ID_WIDTH-1:0]   s_desc_id,
    input  logic [DEST_WIDTH-1:0] s_desc_dest,
    input  logic [USER_WIDTH-1:0] s_desc_user,
    input  logic [7:0]            s_desc_seed,
    input  logic                  s_desc_valid,
    output logic                  s_desc_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_busy,
    output logic                  status_frame_done,
    output logic                  status_bad_desc
);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [7:0]            pattern_q, pattern_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  load_beat;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic                  frame_done_q, frame_done_d;
    logic                  bad_desc_q, bad_desc_d;

    logic [DATA_WIDTH-1:0] gen_tdata;
    logic [KEEP_WIDTH-1:0] gen_tkeep;
    logic                  gen_tlast;

    logic handshake;
    logic last_handshake;
    logic desc_accept;

    assign handshake      = tvalid_q && m_axis_tready;
    assign last_handshake = handshake && tlast_q;
    // Ready also on the final beat's handshake so the next frame follows with no gap.
    assign s_desc_ready   = !rst && ((state_q == StIdle) || last_handshake);
    assign desc_accept    = s_desc_valid && s_desc_ready;

    // Frame sequencing: counters, descriptor latch and state.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        pattern_d    = pattern_q;
        id_d         = id_q;
        dest_d       = dest_q;
        user_d       = user_q;
        load_beat    = 1'b0;
        frame_done_d = 1'b0;
        bad_desc_d   = 1'b0;

        if (handshake) begin
            if (tlast_q) begin
                state_d      = StIdle;
                frame_done_d = 1'b1;
            end else begin
                remaining_d = (remaining_q > LEN_WIDTH'(KEEP_WIDTH)) ?
                              remaining_q - LEN_WIDTH'(KEEP_WIDTH) : '0;
                pattern_d   = pattern_q + 8'(KEEP_WIDTH);
                load_beat   = 1'b1;
            end
        end

        if (desc_accept) begin
            if (s_desc_len == '0) begin
                bad_desc_d = 1'b1;
            end else begin
                state_d     = StSend;
                remaining_d = s_desc_len;
                pattern_d   = s_desc_seed;
                id_d        = s_desc_id;
                dest_d      = s_desc_dest;
                user_d      = s_desc_user;
                load_beat   = 1'b1;
            end
        end
    end

    // Build the beat that the output register will hold next.
    axis_tx_beat_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KEEP_WIDTH  (KEEP_WIDTH),
        .KEEP_ENABLE (KEEP_ENABLE),
        .LEN_WIDTH   (LEN_WIDTH)
    ) u_beat_gen (
        .pattern   (pattern_d),
        .remaining (remaining_d),
        .tdata     (gen_tdata),
        .tkeep     (gen_tkeep),
        .tlast     (gen_tlast)
    );

    // Output register: holds while stalled, reloads on advance or new frame.
    always_comb begin
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tuser_d  = tuser_q;

        if (last_handshake) begin
            tvalid_d = 1'b0;
        end

        if (load_beat) begin
            tdata_d  = gen_tdata;
            tkeep_d  = gen_tkeep;
            tvalid_d = 1'b1;
            tlast_d  = gen_tlast;
            tid_d    = id_d;
            tdest_d  = dest_d;
            tuser_d  = gen_tlast ? user_d : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            pattern_q    <= '0;
            id_q         <= '0;
            dest_q       <= '0;
            user_q       <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tid_q        <= '0;
            tdest_q      <= '0;
            tuser_q      <= '0;
            frame_done_q <= 1'b0;
            bad_desc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            pattern_q    <= pattern_d;
            id_q         <= id_d;
            dest_q       <= dest_d;
            user_q       <= user_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tid_q        <= tid_d;
            tdest_q      <= tdest_d;
            tuser_q      <= tuser_d;
            frame_done_q <= frame_done_d;
            bad_desc_q   <= bad_desc_d;
        end
    end

    assign m_axis_tdata      = tdata_q;
    assign m_axis_tkeep      = tkeep_q;
    assign m_axis_tvalid     = tvalid_q;
    assign m_axis_tlast      = tlast_q;
    assign m_axis_tid        = tid_q;
    assign m_axis_tdest      = tdest_q;
    assign m_axis_tuser      = tuser_q;
    assign status_busy       = (state_q == StSend);
    assign status_frame_done = frame_done_q;
    assign status_bad_desc   = bad_desc_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx: a 32-bit instance (a_*) and an 8-bit instance (b_*).
module tb_axis_frame_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 32-bit instance
    logic [15:0] a_len;
    logic [7:0]  a_id, a_dest, a_seed;
    logic [0:0]  a_user;
    logic        a_valid, a_ready;
    logic [31:0] a_tdata;
    logic [3:0]  a_tkeep;
    logic        a_tvalid, a_tready, a_tlast;
    logic [7:0]  a_tid, a_tdest;
    logic [0:0]  a_tuser;
    logic        a_busy, a_done, a_bad;

    // 8-bit instance
    logic [15:0] b_len;
    logic [7:0]  b_id, b_dest, b_seed;
    logic [0:0]  b_user;
    logic        b_valid, b_ready;
    logic [7:0]  b_tdata;
    logic [0:0]  b_tkeep;
    logic        b_tvalid, b_tready, b_tlast;
    logic [7:0]  b_tid, b_tdest;
    logic [0:0]  b_tuser;
    logic        b_busy, b_done, b_bad;

    int checks = 0;
    int errors = 0;

    axis_frame_tx #(.DATA_WIDTH(32)) dut_a (
        .clk               (clk),
        .rst               (rst),
        .s_desc_len        (a_len),
        .s_desc_id         (a_id),
        .s_desc_dest       (a_dest),
        .s_desc_user       (a_user),
        .s_desc_seed       (a_seed),
        .s_desc_valid      (a_valid),
        .s_desc_ready      (a_ready),
        .m_axis_tdata      (a_tdata),
        .m_axis_tkeep      (a_tkeep),
        .m_axis_tvalid     (a_tvalid),
        .m_axis_tready     (a_tready),
        .m_axis_tlast      (a_tlast),
        .m_axis_tid        (a_tid),
        .m_axis_tdest      (a_tdest),
        .m_axis_tuser      (a_tuser),
        .status_busy       (a_busy),
        .status_frame_done (a_done),
        .status_bad_desc   (a_bad)
    );

    axis_frame_tx #(.DATA_WIDTH(8)) dut_b (
        .clk               (clk),
        .rst               (rst),
        .s_desc_len        (b_len),
        .s_desc_id         (b_id),
        .s_desc_dest       (b_dest),
        .s_desc_user       (b_user),
        .s_desc_seed       (b_seed),
        .s_desc_valid      (b_valid),
        .s_desc_ready      (b_ready),
        .m_axis_tdata      (b_tdata),
        .m_axis_tkeep      (b_tkeep),
        .m_axis_tvalid     (b_tvalid),
        .m_axis_tready     (b_tready),
        .m_axis_tlast      (b_tlast),
        .m_axis_tid        (b_tid),
        .m_axis_tdest      (b_tdest),
        .m_axis_tuser      (b_tuser),
        .status_busy       (b_busy),
        .status_frame_done (b_done),
        .status_bad_desc   (b_bad)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [7:0] got [0:19];
    logic       got_last [0:19];
    int         n;
    logic       prev_stall;
    logic [7:0] prev_data;

    initial begin
        rst = 1'b1;
        a_len = '0; a_id = '0; a_dest = '0; a_user = '0; a_seed = '0; a_valid = 1'b0;
        b_len = '0; b_id = '0; b_dest = '0; b_user = '0; b_seed = '0; b_valid = 1'b0;
        a_tready = 1'b1;
        b_tready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_tvalid", a_tvalid, 1'b0);
        check("rst_desc_ready", a_ready, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_bad", a_bad, 1'b0);
        // Descriptor offered during reset is not taken
        b_len = 16'd2; b_seed = 8'h55; b_valid = 1'b1;
        step();
        check("rst_no_accept", b_tvalid, 1'b0);
        b_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_desc_ready", a_ready, 1'b1);

        // Single frame, 32-bit, len 6, seed 0x10
        a_len = 16'd6; a_seed = 8'h10; a_id = 8'h5A; a_dest = 8'h3C; a_user = 1'b1;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check("f1_b0_tvalid", a_tvalid, 1'b1);
        check("f1_b0_tdata", a_tdata, 32'h13121110);
        check("f1_b0_tkeep", a_tkeep, 4'hF);
        check("f1_b0_tlast", a_tlast, 1'b0);
        check("f1_b0_tuser", a_tuser, 1'b0);
        check("f1_b0_tid", a_tid, 8'h5A);
        check("f1_b0_tdest", a_tdest, 8'h3C);
        check("f1_busy", a_busy, 1'b1);
        step();
        check("f1_b1_tvalid", a_tvalid, 1'b1);
        check("f1_b1_tdata", a_tdata, 32'h00001514);
        check("f1_b1_tkeep", a_tkeep, 4'h3);
        check("f1_b1_tlast", a_tlast, 1'b1);
        check("f1_b1_tuser", a_tuser, 1'b1);
        check("f1_b1_tid", a_tid, 8'h5A);
        check("f1_b1_done_early", a_done, 1'b0);
        step();
        check("f1_end_tvalid", a_tvalid, 1'b0);
        check("f1_done_pulse", a_done, 1'b1);
        check("f1_end_busy", a_busy, 1'b0);
        step();
        check("f1_done_once", a_done, 1'b0);

        // Back-to-back: len 4 seed 0x20, then len 8 seed 0x40
        a_len = 16'd4; a_seed = 8'h20; a_id = 8'h01; a_dest = 8'h02; a_user = 1'b0;
        a_valid = 1'b1;
        step();
        check("b2b_f0_tdata", a_tdata, 32'h23222120);
        check("b2b_f0_tlast", a_tlast, 1'b1);
        a_len = 16'd8; a_seed = 8'h40; a_id = 8'h77; a_dest = 8'h66; a_user = 1'b1;
        #1;
        check("b2b_ready_on_last", a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        check("b2b_f1b0_tvalid", a_tvalid, 1'b1);
        check("b2b_f1b0_tdata", a_tdata, 32'h43424140);
        check("b2b_f1b0_tlast", a_tlast, 1'b0);
        check("b2b_f1b0_tid", a_tid, 8'h77);
        check("b2b_f0_done", a_done, 1'b1);
        step();
        check("b2b_f1b1_tvalid", a_tvalid, 1'b1);
        check("b2b_f1b1_tdata", a_tdata, 32'h47464544);
        check("b2b_f1b1_tlast", a_tlast, 1'b1);
        check("b2b_f1b1_tuser", a_tuser, 1'b1);
        step();
        check("b2b_end_tvalid", a_tvalid, 1'b0);
        check("b2b_f1_done", a_done, 1'b1);

        // Zero-length descriptor
        a_len = 16'd0; a_seed = 8'h99; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        #1;
        check("len0_tvalid", a_tvalid, 1'b0);
        check("len0_bad_pulse", a_bad, 1'b1);
        check("len0_ready", a_ready, 1'b1);
        check("len0_busy", a_busy, 1'b0);
        step();
        check("len0_bad_once", a_bad, 1'b0);
        check("len0_tvalid_after", a_tvalid, 1'b0);

        // Backpressure, 8-bit, len 8 seed 0x80, tready 1,0,0,1,...
        b_len = 16'd8; b_seed = 8'h80; b_id = 8'h11; b_dest = 8'h22; b_user = 1'b1;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        n = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int k = 0; k < 20 && n < 8; k++) begin
            b_tready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            if (prev_stall) begin
                check("bp_hold_tvalid", b_tvalid, 1'b1);
                check("bp_hold_tdata", b_tdata, prev_data);
            end
            if (b_tvalid && b_tready) begin
                got[n] = b_tdata;
                got_last[n] = b_tlast;
                n++;
            end
            prev_stall = b_tvalid && !b_tready;
            prev_data = b_tdata;
            step();
        end
        b_tready = 1'b1;
        check("bp_byte_count", n, 8);
        for (int i = 0; i < 8; i++) begin
            check("bp_byte", got[i], 8'h80 + 8'(i));
        end
        check("bp_last_on_7", got_last[7], 1'b1);
        check("bp_not_last_6", got_last[6], 1'b0);
        check("bp_done", b_done, 1'b1);
        check("bp_end_tvalid", b_tvalid, 1'b0);

        // Wrap: seed 0xFE len 4
        b_len = 16'd4; b_seed = 8'hFE; b_user = 1'b1;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("wrap_b0", b_tdata, 8'hFE);
        check("wrap_b0_last", b_tlast, 1'b0);
        step();
        check("wrap_b1", b_tdata, 8'hFF);
        step();
        check("wrap_b2", b_tdata, 8'h00);
        check("wrap_b2_user", b_tuser, 1'b0);
        step();
        check("wrap_b3", b_tdata, 8'h01);
        check("wrap_b3_last", b_tlast, 1'b1);
        check("wrap_b3_user", b_tuser, 1'b1);
        step();
        check("wrap_end_tvalid", b_tvalid, 1'b0);

        // Reset during beat 2 of a 5-beat frame
        b_len = 16'd5; b_seed = 8'h30; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("rm_b0", b_tdata, 8'h30);
        step();
        check("rm_b1", b_tdata, 8'h31);
        step();
        check("rm_b2", b_tdata, 8'h32);
        rst = 1'b1;
        step();
        check("rm_tvalid_cleared", b_tvalid, 1'b0);
        check("rm_no_done", b_done, 1'b0);
        check("rm_busy_cleared", b_busy, 1'b0);
        rst = 1'b0;
        step();
        check("rm_no_done_later", b_done, 1'b0);
        check("rm_tvalid_stays_low", b_tvalid, 1'b0);
        b_len = 16'd3; b_seed = 8'h70; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("rm_new_b0", b_tdata, 8'h70);
        check("rm_new_b0_valid", b_tvalid, 1'b1);
        step();
        check("rm_new_b1", b_tdata, 8'h71);
        step();
        check("rm_new_b2", b_tdata, 8'h72);
        check("rm_new_b2_last", b_tlast, 1'b1);
        step();
        check("rm_new_done", b_done, 1'b1);
        check("rm_new_end_tvalid", b_tvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
